// File: rtl/float_compare_pipe.sv
// Two-stage IEEE-754 comparator, generic in exponent/mantissa width.
// Stage 1 classifies operands and compares magnitudes; stage 2 resolves the op.
module float_compare_pipe #(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic [2:0]             in_op,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_z,
   output logic                   out_invalid,
   output logic [TAG_W-1:0]       out_tag
);

   localparam int W = 1 + EXP_W + MAN_W;

   logic             adv;

   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] man_a, man_b;
   logic [W-2:0]     mag_a, mag_b;

   logic             s1_valid_d, s1_sa_d, s1_sb_d;
   logic             s1_nan_a_d, s1_nan_b_d, s1_snan_a_d, s1_snan_b_d;
   logic             s1_zero_a_d, s1_zero_b_d;
   logic             s1_mag_lt_d, s1_mag_gt_d, s1_bit_eq_d;

   logic             s1_valid_q, s1_sa_q, s1_sb_q;
   logic             s1_nan_a_q, s1_nan_b_q, s1_snan_a_q, s1_snan_b_q;
   logic             s1_zero_a_q, s1_zero_b_q;
   logic             s1_mag_lt_q, s1_mag_gt_q, s1_bit_eq_q;
   logic [2:0]       s1_op_q;
   logic [TAG_W-1:0] s1_tag_q;

   logic             unord, equal, order, less;
   logic             out_z_d, out_inv_d;

   logic             out_valid_q, out_z_q, out_inv_q;
   logic [TAG_W-1:0] out_tag_q;

   assign adv      = !out_valid_q | out_ready;
   assign in_ready = adv;

   assign exp_a = in_a[W-2:MAN_W];
   assign exp_b = in_b[W-2:MAN_W];
   assign man_a = in_a[MAN_W-1:0];
   assign man_b = in_b[MAN_W-1:0];
   assign mag_a = in_a[W-2:0];
   assign mag_b = in_b[W-2:0];

   assign s1_valid_d  = in_valid;
   assign s1_sa_d     = in_a[W-1];
   assign s1_sb_d     = in_b[W-1];
   assign s1_nan_a_d  = (&exp_a) & (|man_a);
   assign s1_nan_b_d  = (&exp_b) & (|man_b);
   assign s1_snan_a_d = s1_nan_a_d & !man_a[MAN_W-1];
   assign s1_snan_b_d = s1_nan_b_d & !man_b[MAN_W-1];
   assign s1_zero_a_d = ~|mag_a;
   assign s1_zero_b_d = ~|mag_b;
   assign s1_mag_lt_d = mag_a < mag_b;
   assign s1_mag_gt_d = mag_a > mag_b;
   assign s1_bit_eq_d = (s1_sa_d == s1_sb_d) & (mag_a == mag_b);

   // Sign-magnitude ordering: negative magnitudes compare reversed.
   assign unord = s1_nan_a_q | s1_nan_b_q;
   assign equal = !unord & (s1_bit_eq_q | (s1_zero_a_q & s1_zero_b_q));
   assign order = (s1_sa_q != s1_sb_q) ? s1_sa_q :
                  (s1_sa_q ? s1_mag_gt_q : s1_mag_lt_q);
   assign less  = !unord & !equal & order;

   always_comb begin
      out_z_d   = 1'b0;
      out_inv_d = 1'b0;
      unique case (s1_op_q)
         3'd0: out_z_d = equal;
         3'd1: out_z_d = !equal;
         3'd2: out_z_d = less;
         3'd3: out_z_d = less | equal;
         3'd4: out_z_d = !unord & !less & !equal;
         3'd5: out_z_d = !unord & !less;
         3'd6: out_z_d = unord;
         3'd7: out_z_d = 1'b0;
      endcase
      if (s1_op_q != 3'd7) begin
         out_inv_d = s1_snan_a_q | s1_snan_b_q |
                     (unord & (s1_op_q inside {3'd2, 3'd3, 3'd4, 3'd5}));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sa_q     <= 1'b0;
         s1_sb_q     <= 1'b0;
         s1_nan_a_q  <= 1'b0;
         s1_nan_b_q  <= 1'b0;
         s1_snan_a_q <= 1'b0;
         s1_snan_b_q <= 1'b0;
         s1_zero_a_q <= 1'b0;
         s1_zero_b_q <= 1'b0;
         s1_mag_lt_q <= 1'b0;
         s1_mag_gt_q <= 1'b0;
         s1_bit_eq_q <= 1'b0;
         s1_op_q     <= 3'd0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_z_q     <= 1'b0;
         out_inv_q   <= 1'b0;
         out_tag_q   <= '0;
      end else if (adv) begin
         s1_valid_q  <= s1_valid_d;
         s1_sa_q     <= s1_sa_d;
         s1_sb_q     <= s1_sb_d;
         s1_nan_a_q  <= s1_nan_a_d;
         s1_nan_b_q  <= s1_nan_b_d;
         s1_snan_a_q <= s1_snan_a_d;
         s1_snan_b_q <= s1_snan_b_d;
         s1_zero_a_q <= s1_zero_a_d;
         s1_zero_b_q <= s1_zero_b_d;
         s1_mag_lt_q <= s1_mag_lt_d;
         s1_mag_gt_q <= s1_mag_gt_d;
         s1_bit_eq_q <= s1_bit_eq_d;
         s1_op_q     <= in_op;
         s1_tag_q    <= in_tag;
         out_valid_q <= s1_valid_q;
         out_z_q     <= out_z_d;
         out_inv_q   <= out_inv_d;
         out_tag_q   <= s1_tag_q;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_z       = out_z_q;
   assign out_invalid = out_inv_q;
   assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_float_compare_pipe.sv
// Bench for float_compare_pipe: scoreboard against a real-valued reference,
// plus a single-precision instance for reset and width checks.
module tb_float_compare_pipe;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic        out_z, out_invalid;
   logic [63:0] in_a, in_b;
   logic [2:0]  in_op;
   logic [3:0]  in_tag, out_tag;

   logic        s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic        s_out_z, s_out_invalid;
   logic [31:0] s_in_a, s_in_b;
   logic [2:0]  s_in_op;
   logic [3:0]  s_in_tag, s_out_tag;

   float_compare_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_invalid(out_invalid), .out_tag(out_tag)
   );

   float_compare_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut_sp (
      .clk(clk), .rst_n(s_rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_z(s_out_z), .out_invalid(s_out_invalid), .out_tag(s_out_tag)
   );

   typedef struct packed {
      logic       z;
      logic       inv;
      logic [3:0] tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Reference: NaNs by field inspection, ordered values by real arithmetic.
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] op,
                                 output logic z, output logic inv);
      logic na, nb, sna, snb, u, eq, lt, gt;
      real  ra, rb;
      na  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
      nb  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
      sna = na && !a[51];
      snb = nb && !b[51];
      u   = na || nb;
      eq  = 0;
      lt  = 0;
      gt  = 0;
      if (!u) begin
         ra = $bitstoreal(a);
         rb = $bitstoreal(b);
         eq = (ra == rb);
         lt = (ra < rb);
         gt = (ra > rb);
      end
      case (op)
         3'd0:    z = eq;
         3'd1:    z = !eq;
         3'd2:    z = lt;
         3'd3:    z = lt || eq;
         3'd4:    z = gt;
         3'd5:    z = gt || eq;
         3'd6:    z = u;
         default: z = 0;
      endcase
      inv = (op != 3'd7) && (sna || snb || (u && op >= 3'd2 && op <= 3'd5));
   endfunction

   function automatic logic [63:0] pick();
      logic [63:0] r;
      case ($urandom_range(0, 12))
         0:  r = 64'h0000000000000000;
         1:  r = 64'h8000000000000000;
         2:  r = 64'h3FF0000000000000;
         3:  r = 64'hBFF0000000000000;
         4:  r = 64'h7FF0000000000000;
         5:  r = 64'hFFF0000000000000;
         6:  r = 64'h7FF8000000000000;
         7:  r = 64'h7FF0000000000001;
         8:  r = 64'h0000000000000001;
         9:  r = 64'h8000000000000001;
         10: r = 64'h7FEFFFFFFFFFFFFF;
         default: r = {$urandom, $urandom};
      endcase
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] op, input logic [3:0] tag,
                       input bit use_c, input logic cz, input logic cinv);
      bit   acc;
      exp_t e;
      logic mz, minv;
      in_valid = 1; in_a = a; in_b = b; in_op = op; in_tag = tag;
      acc = 0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         chk(0, "accept_timeout", 0, 1);
      end else begin
         model(a, b, op, mz, minv);
         e.z   = use_c ? cz : mz;
         e.inv = use_c ? cinv : minv;
         e.tag = tag;
         sb.push_back(e);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
               chk(0, "spurious_output", {60'd0, out_tag}, 0);
            end else begin
               e = sb[0];
               chk({out_z, out_invalid, out_tag} == e, "result z/inv/tag",
                   {58'd0, out_z, out_invalid, out_tag}, {58'd0, e});
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   endtask

   initial begin
      logic [63:0] a, b;
      bit seen;
      rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_tag = 0;
      out_ready = 1;
      s_rst_n = 0; s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_op = 0;
      s_in_tag = 0; s_out_ready = 1;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1; s_rst_n = 1;
      @(negedge clk);
      chk(in_ready == 1, "reset_in_ready", in_ready, 1);
      chk({out_valid, out_z, out_invalid, out_tag} == 0, "reset_outputs",
          {out_valid, out_z, out_invalid, out_tag}, 0);
      @(posedge clk);
      #1;

      // Latency: tx1 accepted at end of cycle n appears in cycle n+2.
      send(64'h3FF0000000000000, 64'h4000000000000000, 3'd2, 4'd1, 1, 1, 0);
      send(64'h3FF0000000000000, 64'h4000000000000000, 3'd5, 4'd2, 1, 0, 0);
      in_valid = 0;
      chk(out_valid && out_tag == 4'd1 && out_z, "latency_tx1",
          {out_valid, out_z, out_tag}, {1'b1, 1'b1, 4'd1});
      @(posedge clk);
      #1;
      chk(out_valid && out_tag == 4'd2 && !out_z, "latency_tx2",
          {out_valid, out_z, out_tag}, {1'b1, 1'b0, 4'd2});

      send(64'h0000000000000000, 64'h8000000000000000, 3'd0, 4'd3, 1, 1, 0);
      send(64'h0000000000000000, 64'h8000000000000000, 3'd2, 4'd4, 1, 0, 0);
      send(64'h0000000000000000, 64'h8000000000000000, 3'd5, 4'd5, 1, 1, 0);
      send(64'h7FF8000000000000, 64'h3FF0000000000000, 3'd0, 4'd6, 1, 0, 0);
      send(64'h7FF8000000000000, 64'h3FF0000000000000, 3'd1, 4'd7, 1, 1, 0);
      send(64'h7FF8000000000000, 64'h3FF0000000000000, 3'd2, 4'd8, 1, 0, 1);
      send(64'h7FF8000000000000, 64'h3FF0000000000000, 3'd6, 4'd9, 1, 1, 0);
      send(64'h7FF0000000000001, 64'h3FF0000000000000, 3'd0, 4'd10, 1, 0, 1);
      send(64'hBFF0000000000000, 64'h8000000000000001, 3'd2, 4'd11, 1, 1, 0);
      send(64'hFFF0000000000000, 64'hBFF0000000000000, 3'd2, 4'd12, 1, 1, 0);
      send(64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, 3'd4, 4'd13, 1, 1, 0);
      send(64'h7FF0000000000001, 64'h3FF0000000000000, 3'd7, 4'd14, 1, 0, 0);
      in_valid = 0;
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: consumer stalls while four tagged requests arrive.
      fork
         begin
            for (int t = 0; t < 4; t++)
               send(pick(), pick(), 3'($urandom_range(0, 7)), 4'(t), 0, 0, 0);
            in_valid = 0;
         end
         begin
            out_ready = 0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk(in_ready == 0, "bp_in_ready_low", in_ready, 0);
            chk(out_valid == 1 && out_tag == 4'd0, "bp_head_held",
                {out_valid, out_tag}, {1'b1, 4'd0});
            @(posedge clk);
            #1;
            out_ready = 1;
         end
      join
      repeat (4) @(posedge clk);
      #1;

      fork
         begin
            for (int n = 0; n < 300; n++) begin
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 0;
                  @(posedge clk);
                  #1;
               end
               a = pick();
               case ($urandom_range(0, 5))
                  0:       b = a;
                  1:       b = a ^ 64'h8000000000000000;
                  default: b = pick();
               endcase
               send(a, b, 3'($urandom_range(0, 7)), 4'($urandom), 0, 0, 0);
            end
            in_valid = 0;
            done = 1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      out_ready = 1;
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk(sb.size() == 0, "drain_empty", sb.size(), 0);

      // Single precision instance.
      s_in_valid = 1; s_in_a = 32'h3F800000; s_in_b = 32'h3F800000;
      s_in_op = 3'd3; s_in_tag = 4'd5;
      @(posedge clk);
      #1;
      s_in_valid = 0;
      @(posedge clk);
      #1;
      chk(s_out_valid && s_out_z && !s_out_invalid && s_out_tag == 4'd5,
          "sp_le_equal", {s_out_valid, s_out_z, s_out_invalid, s_out_tag},
          {1'b1, 1'b1, 1'b0, 4'd5});
      s_in_valid = 1; s_in_a = 32'h3F800000; s_in_b = 32'h40000000;
      s_in_op = 3'd2; s_in_tag = 4'd6;
      @(posedge clk);
      #1;
      s_in_tag = 4'd7;
      @(posedge clk);
      #1;
      s_in_valid = 0;
      chk(s_out_valid && s_out_z && s_out_tag == 4'd6, "sp_lt_inflight",
          {s_out_valid, s_out_z, s_out_tag}, {1'b1, 1'b1, 4'd6});
      s_rst_n = 0;
      #1;
      chk(!s_out_valid && s_out_tag == 0 && !s_out_z, "sp_reset_clears",
          {s_out_valid, s_out_z, s_out_tag}, 0);
      @(posedge clk);
      #1;
      s_rst_n = 1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (s_out_valid) seen = 1;
      end
      chk(!seen, "sp_no_reemerge", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
